// File: rtl/ddr3_wr_bridge.sv
// ddr3_wr_bridge: CPU-to-DDR3 bridge with a posted-write buffer.
// CPU writes are queued in a DEPTH-entry FIFO and drained to the ram
// in the background. A CPU read first drains all older writes, then
// issues a single ram read and returns its data with a DATA_VALID pulse.
// Requests above the 512 MB window (DATA_ADDR[31:29] != 0) set ERR:
// writes are dropped and reads return zero.
// Optional feature macro: DDR3_WR_BRIDGE_FWD_EN. When it is defined, a
// read that hits a buffered write returns the youngest matching buffered
// data directly, with no drain and no ram read.
module ddr3_wr_bridge #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] DATA_ADDR,
    input  logic [31:0] DATA_BUS,
    input  logic        DATA_ENABLE,
    input  logic        DATA_WRITE,
    output logic [31:0] DATA_OUT,
    output logic        DATA_VALID,
    output logic        STALL,
    output logic        ERR,
    output logic [28:0] addr_out,
    output logic [31:0] write_data_out,
    output logic        read_req,
    output logic        write_req,
    input  logic        read_ready,
    input  logic        write_ready,
    input  logic        please_stall_everything,
    input  logic        read_data_valid,
    input  logic [31:0] read_data_in,
    input  logic        init_calib_complete
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    ptr_t        wr_ptr_reg, rd_ptr_reg;
    logic [28:0] rd_addr_reg;
    logic [31:0] data_out_reg, data_out_next;
    logic        err_reg;

    logic [28:0] fifo_addr_mem [DEPTH];
    logic [31:0] fifo_data_mem [DEPTH];

    logic        empty, full, in_range, cpu_wr, cpu_rd, is_idle, idle_ok;
    logic        push, pop, stall;
    logic        rd_ram, rd_oor, rd_fwd, wr_oor;
    logic        fwd_hit;
    logic [AW-1:0] rd_idx, wr_idx;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign rd_idx   = rd_ptr_reg[AW-1:0];
    assign wr_idx   = wr_ptr_reg[AW-1:0];
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

    assign in_range = (DATA_ADDR[31:29] == 3'b000);
    assign cpu_wr   = DATA_ENABLE & DATA_WRITE;
    assign cpu_rd   = DATA_ENABLE & ~DATA_WRITE;
    assign is_idle  = (state_reg == IDLE);
    assign idle_ok  = is_idle & init_calib_complete;

    // Ram side: writes drain from the FIFO head only while no read owns the bus.
    assign write_req      = ~empty & ((state_reg == IDLE) | (state_reg == DRAIN));
    assign read_req       = (state_reg == RD_ISSUE);
    assign addr_out       = read_req ? rd_addr_reg : fifo_addr_mem[rd_idx];
    assign write_data_out = fifo_data_mem[rd_idx];
    assign pop            = write_req & write_ready & ~please_stall_everything;

    // Classify the CPU request seen while idle.
    assign rd_oor = idle_ok & cpu_rd & ~in_range;
    assign wr_oor = idle_ok & cpu_wr & ~in_range;
    assign rd_fwd = idle_ok & cpu_rd & in_range & fwd_hit;
    assign rd_ram = idle_ok & cpu_rd & in_range & ~fwd_hit;

    assign stall = ~init_calib_complete
                 | (state_reg == DRAIN) | (state_reg == RD_ISSUE) | (state_reg == RD_WAIT)
                 | rd_ram
                 | (is_idle & cpu_wr & in_range & full & ~pop);

    // A push while full is only allowed because the head leaves in the same cycle.
    assign push = idle_ok & cpu_wr & in_range & ~stall;

    assign STALL      = stall;
    assign DATA_OUT   = data_out_reg;
    assign DATA_VALID = (state_reg == DONE);
    assign ERR        = err_reg;

`ifdef DDR3_WR_BRIDGE_FWD_EN
    ptr_t             fifo_count;
    logic [DEPTH-1:0] fwd_match;
    logic [31:0]      fwd_data;
    logic [AW-1:0]    fwd_idx;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;

    // Word-address compare against every slot; occupancy is filtered below.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign fwd_match[gi] = (fifo_addr_mem[gi][28:2] == DATA_ADDR[28:2]);
    end

    // Walk from oldest to youngest so the last hit wins (youngest data).
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_idx + AW'(i);
            if ((ptr_t'(i) < fifo_count) && fwd_match[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_mem[fwd_idx];
            end
        end
    end
`else
    assign fwd_hit = 1'b0;
`endif

    // Next-state and read-data selection.
    always_comb begin
        state_next    = state_reg;
        data_out_next = data_out_reg;
        case (state_reg)
            IDLE: begin
                if (rd_oor) begin
                    data_out_next = '0;
                    state_next    = DONE;
                end else if (rd_fwd) begin
`ifdef DDR3_WR_BRIDGE_FWD_EN
                    data_out_next = fwd_data;
`endif
                    state_next    = DONE;
                end else if (rd_ram) begin
                    state_next = empty ? RD_ISSUE : DRAIN;
                end
            end
            DRAIN: begin
                if (empty) state_next = RD_ISSUE;
            end
            RD_ISSUE: begin
                if (read_ready && !please_stall_everything) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (read_data_valid) begin
                    data_out_next = read_data_in;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state; reset drops buffered writes and any read in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            rd_addr_reg  <= '0;
            data_out_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_out_reg <= data_out_next;
            if (push)   wr_ptr_reg  <= wr_ptr_reg + 1'b1;
            if (pop)    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            if (rd_ram) rd_addr_reg <= DATA_ADDR[28:0];
            if (rd_oor || wr_oor) err_reg <= 1'b1;
        end
    end

    // Buffer storage; contents are don't-care outside the pointer window.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr_mem[wr_idx] <= DATA_ADDR[28:0];
            fifo_data_mem[wr_idx] <= DATA_BUS;
        end
    end

endmodule

// File: tb/tb_ddr3_wr_bridge.sv
// Directed testbench for ddr3_wr_bridge (DEPTH = 4).
// Expectations for the forwarding build are selected with DDR3_WR_BRIDGE_FWD_EN.
module tb_ddr3_wr_bridge;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] DATA_ADDR, DATA_BUS;
    logic        DATA_ENABLE, DATA_WRITE;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID, STALL, ERR;
    logic [28:0] addr_out;
    logic [31:0] write_data_out;
    logic        read_req, write_req;
    logic        read_ready, write_ready, please_stall_everything;
    logic        read_data_valid;
    logic [31:0] read_data_in;
    logic        init_calib_complete;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    logic [31:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    logic [31:0] rlog_addr [$];
    int          ev [$];   // 1 = ram write accepted, 2 = ram read accepted

    ddr3_wr_bridge #(.DEPTH(4)) dut (
        .CLK                     (CLK),
        .RSTn                    (RSTn),
        .DATA_ADDR               (DATA_ADDR),
        .DATA_BUS                (DATA_BUS),
        .DATA_ENABLE             (DATA_ENABLE),
        .DATA_WRITE              (DATA_WRITE),
        .DATA_OUT                (DATA_OUT),
        .DATA_VALID              (DATA_VALID),
        .STALL                   (STALL),
        .ERR                     (ERR),
        .addr_out                (addr_out),
        .write_data_out          (write_data_out),
        .read_req                (read_req),
        .write_req               (write_req),
        .read_ready              (read_ready),
        .write_ready             (write_ready),
        .please_stall_everything (please_stall_everything),
        .read_data_valid         (read_data_valid),
        .read_data_in            (read_data_in),
        .init_calib_complete     (init_calib_complete)
    );

    always #5 CLK = ~CLK;

    // Ram-side transaction log, sampled mid-cycle when everything is settled.
    always @(negedge CLK) begin
        if (write_req && read_req) overlap++;
        if (write_req && write_ready && !please_stall_everything) begin
            wlog_addr.push_back({3'b000, addr_out});
            wlog_data.push_back(write_data_out);
            ev.push_back(1);
            $display("ram write  addr=%h data=%h", addr_out, write_data_out);
        end
        if (read_req && read_ready && !please_stall_everything) begin
            rlog_addr.push_back({3'b000, addr_out});
            ev.push_back(2);
            $display("ram read   addr=%h", addr_out);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        rlog_addr.delete();
        ev.delete();
    endtask

    initial begin
        RSTn = 1'b0;
        DATA_ADDR = '0; DATA_BUS = '0; DATA_ENABLE = 1'b0; DATA_WRITE = 1'b0;
        read_ready = 1'b0; write_ready = 1'b0; please_stall_everything = 1'b0;
        read_data_valid = 1'b0; read_data_in = '0; init_calib_complete = 1'b0;

        // Reset values
        tick();
        chk32("rst_data_out", DATA_OUT, 32'h0);
        chk1("rst_data_valid", DATA_VALID, 1'b0);
        chk1("rst_err", ERR, 1'b0);
        chk1("rst_read_req", read_req, 1'b0);
        chk1("rst_write_req", write_req, 1'b0);
        RSTn = 1'b1;
        tick();

        // Write before calibration is held off, then posted exactly once
        write_ready = 1'b1;
        DATA_ENABLE = 1'b1; DATA_WRITE = 1'b1; DATA_ADDR = 32'h0; DATA_BUS = 32'hDEADBEEF;
        #1;
        chk1("nocal_stall", STALL, 1'b1);
        chk1("nocal_wreq", write_req, 1'b0);
        tick();
        tick();
        chk1("nocal_wreq2", write_req, 1'b0);
        chk32("nocal_wcount", wlog_addr.size(), 32'd0);
        init_calib_complete = 1'b1;
        #1;
        chk1("cal_stall", STALL, 1'b0);
        tick();
        DATA_ENABLE = 1'b0;
        #1;
        chk1("cal_wreq", write_req, 1'b1);
        chk32("cal_addr", {3'b000, addr_out}, 32'h0);
        chk32("cal_wdata", write_data_out, 32'hDEADBEEF);
        tick();
        chk1("cal_wreq_done", write_req, 1'b0);
        tick();
        chk32("cal_wcount", wlog_addr.size(), 32'd1);
        $display("step cal: writes=%0d", wlog_addr.size());

        // Five back-to-back writes into a 4-deep buffer, ram not ready
        clear_logs();
        write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            DATA_ENABLE = 1'b1; DATA_WRITE = 1'b1;
            DATA_ADDR = 32'(4 * i); DATA_BUS = 32'hC0DE0000 + 32'(i);
            #1;
            chk1($sformatf("fill_stall_%0d", i), STALL, (i == 4));
            if (i < 4) tick();
        end
        write_ready = 1'b1;
        #1;
        chk1("full_pop_stall", STALL, 1'b0);
        tick();
        DATA_ENABLE = 1'b0;
        repeat (6) tick();
        chk32("fill_wcount", wlog_addr.size(), 32'd5);
        for (int i = 0; i < 5 && i < wlog_addr.size(); i++) begin
            chk32($sformatf("fill_addr_%0d", i), wlog_addr[i], 32'(4 * i));
            chk32($sformatf("fill_data_%0d", i), wlog_data[i], 32'hC0DE0000 + 32'(i));
        end
        $display("step fill: writes=%0d", wlog_addr.size());

        // Out-of-range read: error, zero data, no ram request
        clear_logs();
        DATA_ENABLE = 1'b1; DATA_WRITE = 1'b0; DATA_ADDR = 32'h70000000;
        #1;
        chk1("oor_stall", STALL, 1'b0);
        tick();
        chk1("oor_err", ERR, 1'b1);
        chk1("oor_valid", DATA_VALID, 1'b1);
        chk32("oor_data", DATA_OUT, 32'h0);
        chk1("oor_rreq", read_req, 1'b0);
        DATA_ENABLE = 1'b0;
        tick();
        chk1("oor_valid_end", DATA_VALID, 1'b0);
        chk1("oor_err_sticky", ERR, 1'b1);
        // Out-of-range write is dropped
        DATA_ENABLE = 1'b1; DATA_WRITE = 1'b1; DATA_ADDR = 32'h20000000; DATA_BUS = 32'h55;
        tick();
        DATA_ENABLE = 1'b0;
        tick();
        tick();
        chk32("oor_ev", ev.size(), 32'd0);
        $display("step oor: ram events=%0d", ev.size());

        // Write 0x40 then read 0x40
        clear_logs();
        write_ready = 1'b0;
        DATA_ENABLE = 1'b1; DATA_WRITE = 1'b1; DATA_ADDR = 32'h40; DATA_BUS = 32'h12345678;
        #1;
        chk1("wr40_stall", STALL, 1'b0);
        tick();
        DATA_WRITE = 1'b0;
        #1;
`ifdef DDR3_WR_BRIDGE_FWD_EN
        chk1("fwd_stall", STALL, 1'b0);
        tick();
        chk1("fwd_valid", DATA_VALID, 1'b1);
        chk32("fwd_data", DATA_OUT, 32'h12345678);
        chk1("fwd_rreq", read_req, 1'b0);
        DATA_ENABLE = 1'b0;
        write_ready = 1'b1;
        repeat (3) tick();
        chk32("fwd_ev_count", ev.size(), 32'd1);
        chk32("fwd_rcount", rlog_addr.size(), 32'd0);
`else
        chk1("rd40_stall", STALL, 1'b1);
        tick();
        chk1("drain_wreq", write_req, 1'b1);
        chk1("drain_rreq", read_req, 1'b0);
        chk32("drain_addr", {3'b000, addr_out}, 32'h40);
        write_ready = 1'b1;
        tick();
        chk1("drain_empty_wreq", write_req, 1'b0);
        chk1("drain_empty_rreq", read_req, 1'b0);
        chk1("drain_empty_stall", STALL, 1'b1);
        tick();
        chk1("issue_rreq", read_req, 1'b1);
        chk32("issue_addr", {3'b000, addr_out}, 32'h40);
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        chk1("wait_rreq", read_req, 1'b0);
        chk1("wait_stall", STALL, 1'b1);
        read_data_valid = 1'b1; read_data_in = 32'h12345678;
        tick();
        read_data_valid = 1'b0;
        chk1("done_valid", DATA_VALID, 1'b1);
        chk32("done_data", DATA_OUT, 32'h12345678);
        chk1("done_stall", STALL, 1'b0);
        DATA_ENABLE = 1'b0;
        tick();
        chk1("idle_valid", DATA_VALID, 1'b0);
        chk32("order_count", ev.size(), 32'd2);
        if (ev.size() == 2) begin
            chk32("order_first_write", 32'(ev[0]), 32'd1);
            chk32("order_then_read", 32'(ev[1]), 32'd2);
        end
`endif
        $display("step rd40: ram events=%0d data_out=%h", ev.size(), DATA_OUT);

        // Reset dropped while waiting for read data
        clear_logs();
        DATA_ENABLE = 1'b1; DATA_WRITE = 1'b0; DATA_ADDR = 32'h100;
        tick();
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        chk1("rw_stall", STALL, 1'b1);
        RSTn = 1'b0;
        DATA_ENABLE = 1'b0;
        #1;
        chk32("arst_data_out", DATA_OUT, 32'h0);
        chk1("arst_valid", DATA_VALID, 1'b0);
        chk1("arst_err", ERR, 1'b0);
        chk1("arst_rreq", read_req, 1'b0);
        chk1("arst_wreq", write_req, 1'b0);
        tick();
        RSTn = 1'b1;
        read_data_valid = 1'b1; read_data_in = 32'h00000BAD;
        tick();
        read_data_valid = 1'b0;
        chk1("late_rdv_valid", DATA_VALID, 1'b0);
        tick();
        chk1("late_rdv_valid2", DATA_VALID, 1'b0);
        chk32("late_rdv_data", DATA_OUT, 32'h0);
        chk1("post_rst_rreq", read_req, 1'b0);
        chk1("post_rst_wreq", write_req, 1'b0);
        $display("step reset: data_out=%h valid=%b", DATA_OUT, DATA_VALID);

        chk32("req_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_wr_bridge.md
DDR3_WR_BRIDGE -- requirements
Module: ddr3_wr_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-buffer entries (power of 2, 2..16).
REQ-002 SHALL have these ports:
- CLK  in  1  clock; the only clock.
- RSTn  in  1  asynchronous active-low reset.
- DATA_ADDR  in  32  CPU byte address.
- DATA_BUS  in  32  CPU write data.
- DATA_ENABLE  in  1  CPU request valid.
- DATA_WRITE  in  1  1 = write, 0 = read.
- DATA_OUT  out  32  read data.
- DATA_VALID  out  1  one-cycle read-complete pulse.
- STALL  out  1  CPU must hold its request.
- ERR  out  1  sticky out-of-range flag.
- addr_out  out  29  ram address.
- write_data_out  out  32  ram write data.
- read_req  out  1  ram read request.
- write_req  out  1  ram write request.
- read_ready  in  1  ram can accept a read.
- write_ready  in  1  ram can accept a write.
- please_stall_everything  in  1  ram busy.
- read_data_valid  in  1  ram read data strobe.
- read_data_in  in  32  ram read data.
- init_calib_complete  in  1  DDR3 calibrated.

Function
REQ-003 SHALL post CPU writes into a DEPTH-entry FIFO of {addr[28:0], data}; push on DATA_ENABLE & DATA_WRITE & ~STALL.
REQ-004 SHALL present the FIFO head on addr_out/write_data_out with write_req = ~empty whenever state is IDLE or DRAIN.
REQ-005 SHALL pop the head on write_req & write_ready & ~please_stall_everything; push and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full.
REQ-006 SHALL implement the states IDLE, DRAIN, RD_ISSUE, RD_WAIT and DONE.
REQ-007 In IDLE, a CPU read (DATA_ENABLE & ~DATA_WRITE, calibration complete) SHALL latch DATA_ADDR[28:0] and go to DRAIN if the FIFO is non-empty, else to RD_ISSUE.
REQ-008 DRAIN SHALL go to RD_ISSUE in the cycle after the FIFO becomes empty; the read never overtakes an older write.
REQ-009 RD_ISSUE SHALL drive read_req = 1 with the latched address, and SHALL go to RD_WAIT on read_ready & ~please_stall_everything.
REQ-010 RD_WAIT SHALL register read_data_in into DATA_OUT on read_data_valid, then go to DONE.
REQ-011 In DONE, DATA_VALID SHALL be 1 and STALL 0; the held CPU request SHALL be ignored; the next state is IDLE.
REQ-012 read_req and write_req SHALL never both be 1.
REQ-013 STALL SHALL be combinational and equal to the OR of:
- ~init_calib_complete;
- state in {DRAIN, RD_ISSUE, RD_WAIT};
- IDLE with a read that is not forwarded;
- a write while the FIFO is full and not popping this cycle.
REQ-014 A request with DATA_ADDR[31:29] != 0 SHALL set ERR and not stall. A write SHALL be dropped. A read SHALL complete in 1 cycle with DATA_OUT = 0 and DATA_VALID = 1.
REQ-015 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty SHALL be derived from the MSB and equality.

Reset
REQ-016 While RSTn = 0 the block SHALL hold:
- FIFO empty, state IDLE;
- DATA_OUT = 0, DATA_VALID = 0, ERR = 0;
- read_req = 0, write_req = 0.
REQ-017 Reset mid-transaction SHALL discard the FIFO contents and any read in flight, with no further ram requests until a new CPU request arrives.

Configuration
REQ-018 With DDR3_WR_BRIDGE_FWD_EN defined, an IDLE read whose address[28:2] matches a FIFO entry SHALL return the youngest matching data the next cycle (DATA_VALID = 1, STALL = 0), with no drain and no ram read.
REQ-019 Without DDR3_WR_BRIDGE_FWD_EN, every in-range read SHALL follow REQ-007..REQ-011.

Verification
REQ-020 Calibration low, write 0x0 / 0xDEADBEEF -> STALL = 1, no write_req; after calibration -> exactly one write_req to 0x0.
REQ-021 5 back-to-back writes with DEPTH = 4 and write_ready = 0 -> STALL on the 5th only; release -> 5 pops in order at addresses 0x0, 0x4, ... 0x10.
REQ-022 Write 0x40 = 0x12345678, then read 0x40 with FWD_EN undefined -> write_req precedes read_req; DATA_OUT = 0x12345678 one cycle after read_data_valid.
REQ-023 Same as REQ-022 with FWD_EN defined -> DATA_VALID the next cycle, no read_req.
REQ-024 Read 0x70000000 -> ERR = 1, DATA_OUT = 0, no ram request.
REQ-025 RSTn dropped in RD_WAIT -> all outputs at reset values; a late read_data_valid produces no DATA_VALID.
